// File: rtl/btn_cond_pkg.sv
// Shared constants for the two-button lock front end: silicon and simulation-scale
// debounce/stuck timings plus the counter-width helper used by each channel.
package btn_cond_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;   // 5 ms at 50 MHz
    localparam int unsigned STUCK_CYCLES_DEF    = 50000000; // 1 s at 50 MHz

    localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
    localparam int unsigned SIM_STUCK_CYCLES    = 16;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, debounced level and rise strobe.
// Optional saturating hold counter and stuck flag when BTN_COND_STUCK_DET_EN is defined.
module btn_debounce
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic btn_reset,
    input  logic i_raw,
    output logic o_db,
    output logic o_rise,
    output logic o_stuck
);

    localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (STUCK_CYCLES < 1) begin : g_bad_stuck
        $error("btn_debounce: STUCK_CYCLES must be at least 1");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_db_d;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: every flop here uses <= so all stages update from pre-edge values;
    // a blocking assignment would collapse the two synchroniser stages into one.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // DEBOUNCE_CYCLES consecutive mismatches seen: accept the new level
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db   = r_db;
    assign o_rise = r_db & ~r_db_d;

`ifdef BTN_COND_STUCK_DET_EN
    localparam int unsigned        HOLD_W   = cnt_width(STUCK_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(STUCK_CYCLES);

    logic [HOLD_W-1:0] r_hold;
    logic              r_stuck;

    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            r_hold  <= '0;
            r_stuck <= 1'b0;
        end else if (!r_db) begin
            r_hold  <= '0;
            r_stuck <= 1'b0;
        end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
            if (r_hold == HOLD_MAX - 1'b1) begin
                r_stuck <= 1'b1;
            end
        end
    end

    assign o_stuck = r_stuck;
`else
    assign o_stuck = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Two-button front end for the combination lock: per-channel debounce plus mutually
// exclusive one-cycle press pulses. Stuck detection is built only with BTN_COND_STUCK_DET_EN.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       btn_reset,
    input  logic       raw_0,
    input  logic       raw_1,
    output logic       btn_0,
    output logic       btn_1,
    output logic [1:0] stuck
);

    logic w_db_0, w_db_1;
    logic w_rise_0, w_rise_1;
    logic w_stuck_0, w_stuck_1;
    logic r_btn_0, r_btn_1;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ch0 (
        .clk       (clk),
        .btn_reset (btn_reset),
        .i_raw     (raw_0),
        .o_db      (w_db_0),
        .o_rise    (w_rise_0),
        .o_stuck   (w_stuck_0)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ch1 (
        .clk       (clk),
        .btn_reset (btn_reset),
        .i_raw     (raw_1),
        .o_db      (w_db_1),
        .o_rise    (w_rise_1),
        .o_stuck   (w_stuck_1)
    );

    // A press counts only while the other button is released, so simultaneous
    // rises and chords never advance the lock and the pulses stay exclusive.
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            r_btn_0 <= 1'b0;
            r_btn_1 <= 1'b0;
        end else begin
            r_btn_0 <= w_rise_0 & ~w_db_1;
            r_btn_1 <= w_rise_1 & ~w_db_0;
        end
    end

    assign btn_0 = r_btn_0;
    assign btn_1 = r_btn_1;
    assign stuck = {w_stuck_1, w_stuck_0};

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner at simulation scale (DEBOUNCE_CYCLES=4, STUCK_CYCLES=16).
// Expected pulses are queued when a press is driven and matched when the DUT pulses.
module tb_btn_conditioner;
    import btn_cond_pkg::*;

    localparam int unsigned D   = SIM_DEBOUNCE_CYCLES;
    localparam int          LAT = D + 3;   // driving negedge to pulse-sampling negedge

`ifdef BTN_COND_STUCK_DET_EN
    localparam logic [1:0] STUCK_EXP = 2'b10;
`else
    localparam logic [1:0] STUCK_EXP = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       btn_reset;
    logic       raw_0;
    logic       raw_1;
    logic       btn_0;
    logic       btn_1;
    logic [1:0] stuck;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic        sym;
        logic [31:0] cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] seen_syms = '0;
    int         n_seen    = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (SIM_STUCK_CYCLES)
    ) dut (
        .clk       (clk),
        .btn_reset (btn_reset),
        .raw_0     (raw_0),
        .raw_1     (raw_1),
        .btn_0     (btn_0),
        .btn_1     (btn_1),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic sym);
        exp_q.push_back('{sym: sym, cyc: 32'(cyc + LAT)});
    endtask

    task automatic press(input logic sym, input int hold, input int gap);
        if (sym) raw_1 = 1'b1;
        else     raw_0 = 1'b1;
        expect_pulse(sym);
        tick(hold);
        raw_0 = 1'b0;
        raw_1 = 1'b0;
        tick(gap);
    endtask

    // Monitor: every pulse must be exclusive and match the head of the scoreboard.
    always @(negedge clk) begin
        if (btn_0 | btn_1) begin
            check("mutex", 32'(btn_0 & btn_1), 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_pulse", 32'({btn_1, btn_0}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_sym", 32'(btn_1), 32'(mon_e.sym));
                check("pulse_cycle", 32'(cyc), mon_e.cyc);
            end
            seen_syms = {seen_syms[6:0], btn_1};
            n_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        btn_reset = 1'b1;
        raw_0     = 1'b0;
        raw_1     = 1'b0;
        tick(3);
        check("reset_btn0", 32'(btn_0), 32'd0);
        check("reset_btn1", 32'(btn_1), 32'd0);
        check("reset_stuck", 32'(stuck), 32'd0);
        btn_reset = 1'b0;
        tick(3);

        // Clean press of button 0, held 20 cycles, then released
        press(1'b0, 20, 12);
        check("clean_stuck", 32'(stuck), 32'd0);

        // Bounce on button 1, then a steady hold
        raw_1 = 1'b1; tick(1);
        raw_1 = 1'b0; tick(1);
        raw_1 = 1'b1; tick(1);
        raw_1 = 1'b0; tick(1);
        press(1'b1, 20, 12);

        // Chord: button 1 joins while button 0 held; only button 0 counts
        raw_0 = 1'b1;
        expect_pulse(1'b0);
        tick(10);
        raw_1 = 1'b1;
        tick(15);
        raw_0 = 1'b0;
        raw_1 = 1'b0;
        tick(12);

        // Simultaneous rise: no pulse at all
        raw_0 = 1'b1;
        raw_1 = 1'b1;
        tick(15);
        raw_0 = 1'b0;
        raw_1 = 1'b0;
        tick(12);

        // Lock code 1,1,0,0,1
        seen_syms = '0;
        n_seen    = 0;
        press(1'b1, 8, 10);
        press(1'b1, 8, 10);
        press(1'b0, 8, 10);
        press(1'b0, 8, 10);
        press(1'b1, 8, 10);
        tick(4);
        check("lock_count", 32'(n_seen), 32'd5);
        check("lock_unlock_code", 32'(seen_syms[4:0]), 32'b11001);

        // Reset while debouncing a held button 0: one pulse after full latency from release
        raw_0 = 1'b1;
        tick(3);
        btn_reset = 1'b1;
        #1;
        check("midreset_btn0", 32'(btn_0), 32'd0);
        tick(2);
        btn_reset = 1'b0;
        expect_pulse(1'b0);
        tick(20);
        raw_0 = 1'b0;
        tick(12);

        // Long hold of button 1 for stuck detection
        raw_1 = 1'b1;
        expect_pulse(1'b1);
        tick(21);
        check("stuck_before", 32'(stuck), 32'd0);
        tick(1);
        check("stuck_set", 32'(stuck), 32'(STUCK_EXP));
        tick(18);
        raw_1 = 1'b0;
        tick(6);
        check("stuck_until_db_low", 32'(stuck), 32'(STUCK_EXP));
        tick(1);
        check("stuck_clear", 32'(stuck), 32'd0);
        tick(10);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
